// File: rtl/fir_stream_adapter.sv
// Stream adapter for the decimating FIR: credit-gated sample issue on the input
// side and an output FIFO that collects filter results for a valid/ready stream.
module fir_stream_adapter #(
  parameter int INPUT_WIDTH     = 32,
  parameter int OUTPUT_WIDTH    = 32,
  parameter int MAX_FILTER_SIZE = 64,
  parameter int FS_WIDTH        = $clog2(MAX_FILTER_SIZE),
  parameter int OUT_DEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              dec_level_cfg,
  input  logic [FS_WIDTH-1:0]     filter_size_cfg,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    fir_input_valid,
  output logic [INPUT_WIDTH-1:0]  fir_input,
  output logic                    fir_init,
  output logic                    fir_flush,
  output logic                    fir_downsample,
  output logic [1:0]              fir_dec_level,
  output logic [FS_WIDTH-1:0]     fir_filter_size,
  input  logic                    fir_output_valid,
  input  logic [OUTPUT_WIDTH-1:0] fir_output,
  input  logic                    fir_error,
  output logic                    busy,
  output logic                    error
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, INIT, RUN, DRAIN, ERR
  } state_t;

  state_t state, state_n;

  logic [2:0]              sc, sc_max;
  logic [CW-1:0]           outst;
  logic [AW:0]             wp, rp, cnt;
  logic [OUTPUT_WIDTH-1:0] mem [OUT_DEPTH];
  logic [1:0]              dec_q;
  logic [FS_WIDTH-1:0]     fs_q;
  logic                    err_q, flush_q;
  logic                    iv_q, ds_q;
  logic [INPUT_WIDTH-1:0]  id_q;

  logic active, last, empty, full, pop;
  logic credit_ok, accept, fault, push;
  logic enter_init, enter_err;

  assign cnt    = wp - rp;
  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(OUT_DEPTH));
  assign pop    = !empty && m_ready;
  assign sc_max = (3'd1 << dec_q) - 3'd1;
  assign last   = (sc == sc_max);

  // Credit covers results already queued plus results still in flight.
  assign credit_ok = ((CW+1)'(outst) + (CW+1)'(cnt))
                     < (CW+1)'(OUT_DEPTH);

  assign active = (state == INIT) || (state == RUN) || (state == DRAIN);
  assign fault  = active && (fir_error || (fir_output_valid &&
                  (outst == '0 || (full && !pop))));
  assign push   = active && fir_output_valid && !fault;
  assign accept = s_valid && s_ready;

  assign enter_init = (state_n == INIT);
  assign enter_err  = (state_n == ERR) && (state != ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = INIT;
      INIT:  state_n = fault ? ERR : RUN;
      RUN: begin
        if (fault)     state_n = ERR;
        else if (stop) state_n = DRAIN;
      end
      DRAIN: begin
        if (fault)                          state_n = ERR;
        else if (outst == '0 && empty) state_n = IDLE;
      end
      ERR:   if (start) state_n = INIT;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    fir_init  = 1'b0;
    fir_flush = flush_q;
    busy      = (state != IDLE);
    unique case (state)
      INIT: begin
        fir_init  = 1'b1;
        fir_flush = 1'b1;
      end
      RUN:     s_ready = !last || credit_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc      <= '0;
      outst   <= '0;
      wp      <= '0;
      rp      <= '0;
      dec_q   <= '0;
      fs_q    <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      iv_q    <= 1'b0;
      ds_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      iv_q    <= accept;
      ds_q    <= accept && last;
      flush_q <= enter_err;
      if (accept) id_q <= s_data;
      if (enter_init) begin
        sc    <= '0;
        outst <= '0;
        wp    <= '0;
        rp    <= '0;
        err_q <= 1'b0;
        dec_q <= dec_level_cfg;
        fs_q  <= filter_size_cfg;
      end else begin
        if (accept) sc <= last ? 3'd0 : sc + 3'd1;
        if (accept && last && !push)      outst <= outst + 1'b1;
        else if (push && !(accept && last)) outst <= outst - 1'b1;
        if (push)      wp    <= wp + 1'b1;
        if (pop)       rp    <= rp + 1'b1;
        if (enter_err) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= fir_output;
  end

  assign m_valid         = !empty;
  assign m_data          = empty ? '0 : mem[rp[AW-1:0]];
  assign fir_input_valid = iv_q;
  assign fir_input       = id_q;
  assign fir_downsample  = ds_q;
  assign fir_dec_level   = dec_q;
  assign fir_filter_size = fs_q;
  assign error           = err_q;

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Directed bench for fir_stream_adapter with a 3-stage filter latency model
// and manual result injection for fault and same-cycle scenarios.
module tb_fir_stream_adapter;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [1:0]  dec_level_cfg;
  logic [5:0]  filter_size_cfg;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        fir_input_valid;
  logic [31:0] fir_input;
  logic        fir_init, fir_flush, fir_downsample;
  logic [1:0]  fir_dec_level;
  logic [5:0]  fir_filter_size;
  logic        fir_output_valid;
  logic [31:0] fir_output;
  logic        fir_error, busy, error;

  int nvec = 0;
  int nmis = 0;

  logic        model_en, inj_v;
  logic [31:0] inj_d;
  logic [2:0]  pv;
  logic [31:0] pd [3];

  logic        ds_q  [$];
  logic [31:0] in_q  [$];
  logic [31:0] out_q [$];

  fir_stream_adapter dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .dec_level_cfg(dec_level_cfg),
    .filter_size_cfg(filter_size_cfg),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_input_valid(fir_input_valid), .fir_input(fir_input),
    .fir_init(fir_init), .fir_flush(fir_flush),
    .fir_downsample(fir_downsample),
    .fir_dec_level(fir_dec_level),
    .fir_filter_size(fir_filter_size),
    .fir_output_valid(fir_output_valid),
    .fir_output(fir_output), .fir_error(fir_error),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // filter model: result = sample + 0x100, three stages after issue
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], model_en && fir_input_valid && fir_downsample};
      pd[0] <= fir_input + 32'h100;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  end

  assign fir_output_valid = pv[2] | inj_v;
  assign fir_output       = inj_v ? inj_d : pd[2];

  always @(posedge clk) begin
    if (!rst && fir_input_valid) begin
      ds_q.push_back(fir_downsample);
      in_q.push_back(fir_input);
    end
    if (!rst && m_valid && m_ready) out_q.push_back(m_data);
  end

  task automatic clear_q();
    ds_q.delete();
    in_q.delete();
    out_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] d, input logic [5:0] fs);
    dec_level_cfg   = d;
    filter_size_cfg = fs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] d);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      nvec++; nmis++;
      $display("FAIL send_timeout: s_ready stuck 0 for data %h", d);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic inject(input logic [31:0] d);
    inj_v = 1'b1;
    inj_d = d;
    @(negedge clk);
    inj_v = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    nvec++;
    if (busy !== 1'b0) begin
      nmis++;
      $display("FAIL %s: busy=%b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({s_ready, m_valid, fir_input_valid, fir_init, fir_flush,
         fir_downsample, busy, error} !== 8'h00) begin
      nmis++;
      $display("FAIL rst_flags: got %b want 00000000",
        {s_ready, m_valid, fir_input_valid, fir_init, fir_flush,
         fir_downsample, busy, error});
    end
    nvec++;
    if ({m_data, fir_input, fir_dec_level, fir_filter_size} !== '0) begin
      nmis++;
      $display("FAIL rst_data: m_data=%h fir_input=%h dl=%0d fs=%0d want 0",
        m_data, fir_input, fir_dec_level, fir_filter_size);
    end
  endtask

  task automatic test_dec0();
    int ones = 0;
    clear_q();
    model_en = 1'b1;
    m_ready  = 1'b1;
    do_start(2'd0, 6'd8);
    nvec++;
    if ({fir_init, fir_flush, busy} !== 3'b111) begin
      nmis++;
      $display("FAIL init_strobes: got %b want 111",
        {fir_init, fir_flush, busy});
    end
    @(negedge clk);
    nvec++;
    if (fir_dec_level !== 2'd0 || fir_filter_size !== 6'd8) begin
      nmis++;
      $display("FAIL cfg0: dl=%0d fs=%0d want 0/8",
        fir_dec_level, fir_filter_size);
    end
    for (int i = 0; i < 5; i++) send_sample(32'h10 + i);
    repeat (20) @(negedge clk);
    foreach (ds_q[i]) if (ds_q[i]) ones++;
    nvec++;
    if (ds_q.size() !== 5 || ones !== 5) begin
      nmis++;
      $display("FAIL dec0_issue: issues=%0d ds=%0d want 5/5",
        ds_q.size(), ones);
    end
    nvec++;
    if (out_q.size() !== 5) begin
      nmis++;
      $display("FAIL dec0_count: got %0d want 5", out_q.size());
    end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      nvec++;
      if (out_q[i] !== 32'h110 + i) begin
        nmis++;
        $display("FAIL dec0_data%0d: got %h want %h",
          i, out_q[i], 32'h110 + i);
      end
    end
    pulse_stop();
    wait_idle("dec0_idle");
  endtask

  task automatic test_dec2();
    logic [7:0] mask = '0;
    clear_q();
    model_en = 1'b1;
    m_ready  = 1'b1;
    do_start(2'd2, 6'd16);
    @(negedge clk);
    nvec++;
    if (fir_dec_level !== 2'd2 || fir_filter_size !== 6'd16) begin
      nmis++;
      $display("FAIL cfg2: dl=%0d fs=%0d want 2/16",
        fir_dec_level, fir_filter_size);
    end
    for (int i = 0; i < 8; i++) send_sample(32'h20 + i);
    repeat (20) @(negedge clk);
    foreach (ds_q[i]) if (i < 8) mask[i] = ds_q[i];
    nvec++;
    if (ds_q.size() !== 8 || mask !== 8'b1000_1000) begin
      nmis++;
      $display("FAIL dec2_ds: n=%0d mask=%b want 8/10001000",
        ds_q.size(), mask);
    end
    nvec++;
    if (out_q.size() !== 2) begin
      nmis++;
      $display("FAIL dec2_count: got %0d want 2", out_q.size());
    end else begin
      nvec++;
      if (out_q[0] !== 32'h123 || out_q[1] !== 32'h127) begin
        nmis++;
        $display("FAIL dec2_data: got %h %h want 123 127",
          out_q[0], out_q[1]);
      end
    end
    pulse_stop();
    wait_idle("dec2_idle");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    clear_q();
    model_en = 1'b1;
    m_ready  = 1'b0;
    do_start(2'd0, 6'd8);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'h40;
    repeat (30) begin
      if (s_ready) acc++;
      @(negedge clk);
      s_data = 32'h40 + acc;
    end
    nvec++;
    if (acc !== 4 || s_ready !== 1'b0) begin
      nmis++;
      $display("FAIL bp_fill: accepted=%0d s_ready=%b want 4/0",
        acc, s_ready);
    end
    m_ready = 1'b1;
    nvec++;
    if (s_ready !== 1'b0) begin
      nmis++;
      $display("FAIL bp_prepop: s_ready=%b want 0", s_ready);
    end
    @(negedge clk);
    nvec++;
    if (s_ready !== 1'b1) begin
      nmis++;
      $display("FAIL bp_resume: s_ready=%b want 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    nvec++;
    if (out_q.size() !== 5) begin
      nmis++;
      $display("FAIL bp_count: got %0d want 5", out_q.size());
    end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      nvec++;
      if (out_q[i] !== 32'h140 + i) begin
        nmis++;
        $display("FAIL bp_data%0d: got %h want %h",
          i, out_q[i], 32'h140 + i);
      end
    end
    pulse_stop();
    wait_idle("bp_idle");
  endtask

  task automatic test_same_cycle();
    clear_q();
    model_en = 1'b0;
    m_ready  = 1'b0;
    do_start(2'd1, 6'd4);
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_sample(32'h60 + i);
    for (int i = 0; i < 3; i++) inject(32'hA0 + i);
    send_sample(32'h70);
    send_sample(32'h71);
    nvec++;
    if (s_ready !== 1'b1 || m_valid !== 1'b1) begin
      nmis++;
      $display("FAIL sc_pre: s_ready=%b m_valid=%b want 1/1",
        s_ready, m_valid);
    end
    s_valid = 1'b1;
    s_data  = 32'h72;
    inj_v   = 1'b1;
    inj_d   = 32'hA3;
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    inj_v   = 1'b0;
    nvec++;
    if (error !== 1'b0 || m_valid !== 1'b1) begin
      nmis++;
      $display("FAIL sc_noerr: error=%b m_valid=%b want 0/1",
        error, m_valid);
    end
    repeat (8) @(negedge clk);
    nvec++;
    if (out_q.size() !== 4) begin
      nmis++;
      $display("FAIL sc_count: got %0d want 4", out_q.size());
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      nvec++;
      if (out_q[i] !== 32'hA0 + i) begin
        nmis++;
        $display("FAIL sc_data%0d: got %h want %h",
          i, out_q[i], 32'hA0 + i);
      end
    end
    pulse_stop();
    wait_idle("sc_idle");
  endtask

  task automatic test_error();
    model_en = 1'b1;
    m_ready  = 1'b1;
    do_start(2'd0, 6'd8);
    @(negedge clk);
    fir_error = 1'b1;
    @(negedge clk);
    fir_error = 1'b0;
    nvec++;
    if ({error, fir_flush, s_ready, busy} !== 4'b1101) begin
      nmis++;
      $display("FAIL err_entry: err,flush,rdy,busy=%b want 1101",
        {error, fir_flush, s_ready, busy});
    end
    @(negedge clk);
    nvec++;
    if ({error, fir_flush} !== 2'b10) begin
      nmis++;
      $display("FAIL err_hold: err,flush=%b want 10",
        {error, fir_flush});
    end
    do_start(2'd0, 6'd8);
    nvec++;
    if ({fir_init, error} !== 2'b10) begin
      nmis++;
      $display("FAIL err_restart: init,err=%b want 10",
        {fir_init, error});
    end
    @(negedge clk);
  endtask

  task automatic test_unsolicited_rst();
    nvec++;
    if (s_ready !== 1'b1) begin
      nmis++;
      $display("FAIL uns_pre: s_ready=%b want 1", s_ready);
    end
    inject(32'hDEAD);
    nvec++;
    if (error !== 1'b1 || busy !== 1'b1) begin
      nmis++;
      $display("FAIL uns_err: error=%b busy=%b want 1/1", error, busy);
    end
    m_ready = 1'b0;
    do_start(2'd3, 6'd12);
    @(negedge clk);
    send_sample(32'h80);
    for (int i = 0; i < 7; i++) send_sample(32'h81 + i);
    repeat (8) @(negedge clk);
    nvec++;
    if (m_valid !== 1'b1 || m_data !== 32'h187) begin
      nmis++;
      $display("FAIL rst_pre: m_valid=%b m_data=%h want 1/187",
        m_valid, m_data);
    end
    s_valid = 1'b1;
    s_data  = 32'h99;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    nvec++;
    if ({s_ready, m_valid, fir_input_valid, fir_init, fir_flush,
         fir_downsample, busy, error} !== 8'h00) begin
      nmis++;
      $display("FAIL midrst_flags: got %b want 00000000",
        {s_ready, m_valid, fir_input_valid, fir_init, fir_flush,
         fir_downsample, busy, error});
    end
    nvec++;
    if ({m_data, fir_input, fir_dec_level, fir_filter_size} !== '0) begin
      nmis++;
      $display("FAIL midrst_data: m_data=%h in=%h dl=%0d fs=%0d want 0",
        m_data, fir_input, fir_dec_level, fir_filter_size);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    dec_level_cfg = '0;
    filter_size_cfg = '0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    fir_error = 1'b0;
    model_en = 1'b0;
    inj_v = 1'b0;
    inj_d = '0;
    @(negedge clk);
    test_reset();
    test_dec0();
    test_dec2();
    test_backpressure();
    test_same_cycle();
    test_error();
    test_unsolicited_rst();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
